// File: rtl/frame_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_fetch_ctrl
// Description : Display-side read scheduler for the PROM->FIFO pixel loader.
//               Places the upscaled image in a panel window, gates loader
//               reads to that window and emits registered RGB888 pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_fetch_ctrl #(
    parameter int          IMG_W        = 450,
    parameter int          IMG_H        = 450,
    parameter int          X_OFF        = 175,
    parameter int          Y_OFF        = 15,
    parameter int          PRIME_CYCLES = 64,
    parameter logic [23:0] BORDER_RGB   = 24'h000000,
    parameter logic [23:0] UFLOW_RGB    = 24'hFF0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic        i_clr_err,
    output logic        o_next,
    output logic [23:0] o_rgb,
    output logic        o_de,
    output logic        o_vsync,
    output logic        o_underflow,
    output logic [15:0] o_frame_cnt
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SYNC   = 2'd1;
    localparam logic [1:0] c_PRIME  = 2'd2;
    localparam logic [1:0] c_ACTIVE = 2'd3;

    localparam int              c_PW         = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
    localparam logic [c_PW-1:0] c_PRIME_LAST = c_PW'(PRIME_CYCLES - 1);
    localparam logic [10:0]     c_X_LO       = 11'(X_OFF);
    localparam logic [10:0]     c_X_HI       = 11'(X_OFF + IMG_W);
    localparam logic [10:0]     c_Y_LO       = 11'(Y_OFF);
    localparam logic [10:0]     c_Y_HI       = 11'(Y_OFF + IMG_H);
    localparam logic [9:0]      c_CNT_MAX    = 10'h3FF;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            w_frame_inc;
    logic [c_PW-1:0] r_prime_cnt;
    logic [9:0]      r_x_cnt;
    logic [9:0]      r_y_cnt;
    logic [23:0]     r_rgb;
    logic            r_de;
    logic            r_vsync;
    logic            r_underflow;
    logic [15:0]     r_frame_cnt;
    logic            w_in_win;

    always_comb begin
        w_state_nxt = r_state;
        w_frame_inc = 1'b0;
        case (r_state)
            c_IDLE:   if (!i_vsync) w_state_nxt = c_SYNC;
            c_SYNC:   if (i_vsync) w_state_nxt = i_enable ? c_PRIME : c_IDLE;
            c_PRIME: begin
                if (!i_vsync)
                    w_state_nxt = c_SYNC;
                else if (r_prime_cnt == c_PRIME_LAST)
                    w_state_nxt = c_ACTIVE;
            end
            c_ACTIVE: begin
                if (!i_vsync) begin
                    w_state_nxt = c_SYNC;
                    w_frame_inc = 1'b1;
                end
            end
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_prime_cnt <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Counter only runs while staying in PRIME, so each entry starts from zero.
            if (r_state == c_PRIME && w_state_nxt == c_PRIME)
                r_prime_cnt <= r_prime_cnt + 1'b1;
            else
                r_prime_cnt <= '0;
            if (w_frame_inc)
                r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Raster position: x counts DE cycles, y counts completed DE runs since vsync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_cnt <= '0;
            r_y_cnt <= '0;
        end else begin
            if (!i_de)
                r_x_cnt <= '0;
            else if (r_x_cnt != c_CNT_MAX)
                r_x_cnt <= r_x_cnt + 10'd1;
            if (!i_vsync)
                r_y_cnt <= '0;
            else if (r_de && !i_de && r_y_cnt != c_CNT_MAX)
                r_y_cnt <= r_y_cnt + 10'd1;
        end
    end

    assign w_in_win = (r_state == c_ACTIVE) && i_vsync && i_de &&
                      ({1'b0, r_x_cnt} >= c_X_LO) && ({1'b0, r_x_cnt} < c_X_HI) &&
                      ({1'b0, r_y_cnt} >= c_Y_LO) && ({1'b0, r_y_cnt} < c_Y_HI);

    assign o_next = w_in_win && i_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb       <= '0;
            r_de        <= 1'b0;
            r_vsync     <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            r_de    <= i_de;
            r_vsync <= i_vsync;
            if (!i_de)
                r_rgb <= '0;
            else if (!w_in_win)
                r_rgb <= BORDER_RGB;
            else if (i_valid)
                r_rgb <= {i_data, i_data, i_data};
            else
                r_rgb <= UFLOW_RGB;
            if (w_in_win && !i_valid)
                r_underflow <= 1'b1;
            else if (i_clr_err)
                r_underflow <= 1'b0;
        end
    end

    assign o_rgb       = r_rgb;
    assign o_de        = r_de;
    assign o_vsync     = r_vsync;
    assign o_underflow = r_underflow;
    assign o_frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_fetch_ctrl
// Description : Directed frames against a reduced-size instance with a
//               cycle model, plus a default-size instance for window placement.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_fetch_ctrl;

    localparam int c_W  = 5;
    localparam int c_H  = 3;
    localparam int c_XO = 2;
    localparam int c_YO = 1;
    localparam int c_PR = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable, i_vsync, i_de, i_valid, i_clr_err;
    logic [7:0]  i_data;
    logic        o_next, o_de, o_vsync, o_underflow;
    logic [23:0] o_rgb;
    logic [15:0] o_frame_cnt;
    logic        b_next, b_de, b_vsync, b_underflow;
    logic [23:0] b_rgb;
    logic [15:0] b_frame_cnt;

    always #5 clk = ~clk;

    frame_fetch_ctrl #(
        .IMG_W(c_W), .IMG_H(c_H), .X_OFF(c_XO), .Y_OFF(c_YO), .PRIME_CYCLES(c_PR),
        .BORDER_RGB(24'h000000), .UFLOW_RGB(24'hFF0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_vsync(i_vsync), .i_de(i_de),
        .i_valid(i_valid), .i_data(i_data), .i_clr_err(i_clr_err), .o_next(o_next),
        .o_rgb(o_rgb), .o_de(o_de), .o_vsync(o_vsync), .o_underflow(o_underflow),
        .o_frame_cnt(o_frame_cnt)
    );

    frame_fetch_ctrl big (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_vsync(i_vsync), .i_de(i_de),
        .i_valid(i_valid), .i_data(i_data), .i_clr_err(i_clr_err), .o_next(b_next),
        .o_rgb(b_rgb), .o_de(b_de), .o_vsync(b_vsync), .o_underflow(b_underflow),
        .o_frame_cnt(b_frame_cnt)
    );

    int tests = 0;
    int fails = 0;
    int drv_x = 0;
    int drv_y = 0;
    int nxt_cnt = 0, gray_cnt = 0, red_cnt = 0;
    int b_cnt = 0, b_bad = 0, b_edge = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: a frame is fetchable once enabled at vsync rise and the priming time has passed.
    logic        m_armed = 1'b0;
    int          m_wait = 0;
    logic        m_prev_vs = 1'b1;
    logic [15:0] m_fc = '0;
    logic        m_uf = 1'b0;
    logic [23:0] e_rgb = '0;
    logic        e_de = 1'b0, e_vs = 1'b1, e_uf = 1'b0;
    logic [15:0] e_fc = '0;
    logic        win;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_next", {31'd0, o_next}, 32'd0);
            chk("rst_rgb", {8'd0, o_rgb}, 32'd0);
            chk("rst_de", {31'd0, o_de}, 32'd0);
            chk("rst_vsync", {31'd0, o_vsync}, 32'd1);
            chk("rst_uflow", {31'd0, o_underflow}, 32'd0);
            chk("rst_fcnt", {16'd0, o_frame_cnt}, 32'd0);
            m_armed = 1'b0; m_wait = 0; m_prev_vs = 1'b1; m_fc = '0; m_uf = 1'b0;
            e_rgb = '0; e_de = 1'b0; e_vs = 1'b1; e_uf = 1'b0; e_fc = '0;
        end else begin
            chk("rgb", {8'd0, o_rgb}, {8'd0, e_rgb});
            chk("de", {31'd0, o_de}, {31'd0, e_de});
            chk("vsync", {31'd0, o_vsync}, {31'd0, e_vs});
            chk("uflow", {31'd0, o_underflow}, {31'd0, e_uf});
            chk("fcnt", {16'd0, o_frame_cnt}, {16'd0, e_fc});
            win = m_armed && (m_wait == 0) && i_vsync && i_de &&
                  drv_x >= c_XO && drv_x < c_XO + c_W && drv_y >= c_YO && drv_y < c_YO + c_H;
            chk("next", {31'd0, o_next}, {31'd0, win && i_valid});
            if (o_next) nxt_cnt++;
            if (o_rgb == 24'h5A5A5A) gray_cnt++;
            if (o_rgb == 24'hFF0000) red_cnt++;
            if (b_next) begin
                b_cnt++;
                if (drv_x < 175 || drv_x > 624 || drv_y < 15 || drv_y > 464) b_bad++;
                if (drv_x == 175 || drv_x == 624) b_edge++;
            end
            e_rgb = !i_de ? 24'h0 : !win ? 24'h0 : i_valid ? {3{i_data}} : 24'hFF0000;
            e_de = i_de;
            e_vs = i_vsync;
            if (win && !i_valid) m_uf = 1'b1;
            else if (i_clr_err) m_uf = 1'b0;
            e_uf = m_uf;
            if (!i_vsync) begin
                if (m_armed && m_wait == 0) m_fc = m_fc + 16'd1;
                m_armed = 1'b0;
            end else if (!m_prev_vs) begin
                m_armed = i_enable;
                m_wait = c_PR;
            end else if (m_wait > 0) begin
                m_wait--;
            end
            m_prev_vs = i_vsync;
            e_fc = m_fc;
        end
    end

    task automatic drive(input logic vs, input logic de, input logic valid, input logic [7:0] data,
                         input logic clr, input int x, input int y);
        i_vsync = vs; i_de = de; i_valid = valid; i_data = data; i_clr_err = clr;
        drv_x = x; drv_y = y;
        @(posedge clk);
        #1;
    endtask

    int base_n, base_g, base_r;

    task automatic frame(input int vs_len, input int vbp, input int hb, input int pw, input int lines,
                         input logic en, input int uf_x, input int uf_y, input logic fixed_data);
        logic       hit;
        logic [7:0] d;
        i_enable = en;
        base_n = nxt_cnt; base_g = gray_cnt; base_r = red_cnt;
        for (int i = 0; i < vs_len; i++) drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0);
        for (int i = 0; i < vbp; i++) drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0);
        for (int l = 0; l < lines; l++) begin
            for (int i = 0; i < hb; i++) drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0, l);
            for (int p = 0; p < pw; p++) begin
                hit = (p == uf_x) && (l == uf_y);
                d = fixed_data ? 8'h5A : 8'(p * 7 + l * 3);
                drive(1'b1, 1'b1, !hit, d, hit, p, l);
            end
        end
        for (int i = 0; i < hb; i++) drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0, lines);
    endtask

    int b_base, b_edge_base;

    initial begin
        rst_n = 1'b0;
        i_enable = 1'b0; i_vsync = 1'b1; i_de = 1'b0; i_valid = 1'b1; i_data = 8'h00; i_clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0);

        // Priming frame: line 1 window falls inside the priming interval, lines 2-3 fetch.
        frame(3, 0, 2, 10, 6, 1'b1, -1, -1, 1'b0);
        chk("prime_next_cnt", 32'(nxt_cnt - base_n), 32'd10);

        frame(3, 20, 2, 10, 6, 1'b1, -1, -1, 1'b1);
        chk("full_next_cnt", 32'(nxt_cnt - base_n), 32'd15);
        chk("gray_cnt", 32'(gray_cnt - base_g), 32'd15);
        chk("fcnt_after_b", {16'd0, o_frame_cnt}, 32'd1);

        // Reset while ACTIVE.
        rst_n = 1'b0;
        #2;
        chk("midrst_next", {31'd0, o_next}, 32'd0);
        chk("midrst_fcnt", {16'd0, o_frame_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0);

        frame(3, 20, 2, 5, 3, 1'b1, -1, -1, 1'b0);
        chk("clip_next_cnt", 32'(nxt_cnt - base_n), 32'd6);

        frame(3, 20, 2, 10, 6, 1'b1, 3, 2, 1'b0);
        chk("uflow_next_cnt", 32'(nxt_cnt - base_n), 32'd14);
        chk("uflow_red_cnt", 32'(red_cnt - base_r), 32'd1);
        chk("uflow_sticky", {31'd0, o_underflow}, 32'd1);
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 0, 0);
        chk("uflow_cleared", {31'd0, o_underflow}, 32'd0);

        frame(3, 20, 2, 10, 6, 1'b0, -1, -1, 1'b0);
        chk("disabled_next_cnt", 32'(nxt_cnt - base_n), 32'd0);
        chk("fcnt_after_e", {16'd0, o_frame_cnt}, 32'd2);

        // Short frame: vsync returns low while still priming.
        frame(3, 5, 1, 0, 0, 1'b1, -1, -1, 1'b0);

        b_base = b_cnt; b_edge_base = b_edge;
        frame(3, 70, 4, 800, 17, 1'b1, -1, -1, 1'b0);
        chk("big_small_next_cnt", 32'(nxt_cnt - base_n), 32'd15);
        chk("big_next_cnt", 32'(b_cnt - b_base), 32'd900);
        chk("big_out_of_window", 32'(b_bad), 32'd0);
        chk("big_edge_cols", 32'(b_edge - b_edge_base), 32'd4);
        chk("fcnt_after_abort", {16'd0, o_frame_cnt}, 32'd2);

        repeat (3) drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0, 0);
        chk("fcnt_final", {16'd0, o_frame_cnt}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
